// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB3 completer with a small word memory, a programmable wait-state count and PSLVERR for out-of-range words.
// Optional APB_RAND_WAIT_EN: the per-transfer wait count comes from an 8-bit LFSR instead of WAIT_CYCLES.
module apb_wait_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W              = ADDR_WIDTH - 2;
  localparam int MEM_AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0] WAIT_L     = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  err_q, err_d;
  logic [MEM_AW-1:0]     idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;

  logic [IDX_W-1:0]      paddr_idx;
  logic                  new_err;
  logic [3:0]            wait_load;
  logic                  setup_hit, last_wait, respond, complete, abort;
  logic                  resp_write, resp_err;
  logic [MEM_AW-1:0]     resp_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_paddr_lsb;

  assign paddr_idx        = PADDR[ADDR_WIDTH-1:2];
  assign unused_paddr_lsb = ^PADDR[1:0];
  assign new_err          = {1'b0, paddr_idx} >= DEPTH_L;

`ifdef APB_RAND_WAIT_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci taps 8,6,5,4; free-running regardless of bus activity.
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign wait_load = {2'b00, lfsr_q[1:0]};
`else
  assign wait_load = WAIT_L;
`endif

  // Bus events seen on the current edge.
  always_comb begin
    setup_hit = (state_q == IDLE) && PSEL && !PENABLE;
    last_wait = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd1);
    respond   = (setup_hit && (wait_load == 4'd0)) || last_wait;
    complete  = (state_q == DONE) && PSEL && PENABLE && pready_q;
    abort     = (state_q != IDLE) && !PSEL;
  end

  // The zero-wait path answers from the live setup inputs, the wait path from the latch.
  always_comb begin
    resp_write = setup_hit ? PWRITE : pwrite_q;
    resp_err   = setup_hit ? new_err : err_q;
    resp_idx   = setup_hit ? paddr_idx[MEM_AW-1:0] : idx_q;
    rd_word    = mem_q[resp_idx];
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      pwrite_q  <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      pwrite_q  <= pwrite_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      if (mem_we) mem_q[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup_hit) state_d = (wait_load == 4'd0) ? DONE : ACCESS;
      ACCESS:  if (abort) state_d = IDLE;
               else if (last_wait) state_d = DONE;
      DONE:    if (abort || complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    pwrite_d  = pwrite_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    mem_we    = 1'b0;

    if (setup_hit) begin
      pwrite_d = PWRITE;
      err_d    = new_err;
      idx_d    = paddr_idx[MEM_AW-1:0];
      wdata_d  = PWDATA;
      cnt_d    = wait_load;
    end

    if ((state_q == ACCESS) && PSEL && PENABLE) cnt_d = cnt_q - 4'd1;

    if (respond) begin
      pready_d  = 1'b1;
      pslverr_d = resp_err;
      prdata_d  = (!resp_write && !resp_err) ? rd_word : '0;
    end

    if (complete || abort) begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      cnt_d     = '0;
    end

    mem_we = complete && pwrite_q && !err_q;
  end

  always_comb begin
    PREADY  = pready_q;
    PRDATA  = prdata_q;
    PSLVERR = pslverr_q;
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0, shared bus except PSEL.
module tb_apb_wait_slave;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        psel2 = 1'b0, psel0 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pready2, pslverr2, pready0, pslverr0;
  logic [31:0] prdata2, prdata0;
  logic [7:0]  lfsr_m;

  int vec_n = 0;
  int miss_n = 0;

  apb_wait_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready2), .PRDATA(prdata2), .PSLVERR(pslverr2));

  apb_wait_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0));

  always #5 PCLK = ~PCLK;

  // Reference LFSR: taps 8,6,5,4, seed A5.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  // Called at posedge+1; returns at posedge+1 just after the completion edge with the bus idle.
  task automatic xfer(input bit z, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      input bit scramble, output int waits, output logic [31:0] rd,
                      output logic er, output logic [1:0] lf);
    bit got;
    waits = 0; rd = '0; er = 1'b0; got = 0;
    psel2 = !z; psel0 = z; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge PCLK);
    lf = lfsr_m[1:0];
    @(posedge PCLK); #1;
    penable = 1'b1;
    if (scramble) begin paddr = 8'h14; pwdata = 32'h0; end
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if ((z ? pready0 : pready2) === 1'b1) begin
        rd = z ? prdata0 : prdata2;
        er = z ? pslverr0 : pslverr2;
        got = 1;
        break;
      end
      waits++;
    end
    if (!got) begin
      vec_n++; miss_n++;
      $display("FAIL xfer_timeout addr=%h: PREADY never rose within 40 cycles", addr);
    end
    @(posedge PCLK); #1;
    psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    vec_n++; if ({pready2, pslverr2, prdata2} !== 34'h0) begin miss_n++; $display("FAIL reset_out2 got %h want 0", {pready2, pslverr2, prdata2}); end
    vec_n++; if ({pready0, pslverr0, prdata0} !== 34'h0) begin miss_n++; $display("FAIL reset_out0 got %h want 0", {pready0, pslverr0, prdata0}); end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      vec_n++; if ({pready2, pslverr2, prdata2} !== 34'h0) begin miss_n++; $display("FAIL idle_out cycle %0d got %h want 0", i, {pready2, pslverr2, prdata2}); end
    end
    // PENABLE without a setup phase must be ignored.
    @(posedge PCLK); #1;
    psel2 = 1'b1; penable = 1'b1; paddr = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      vec_n++; if (pready2 !== 1'b0) begin miss_n++; $display("FAIL no_setup_ready cycle %0d got %b want 0", i, pready2); end
    end
    @(posedge PCLK); #1;
    psel2 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_zero_wait;
    int w; logic [31:0] rd; logic er; logic [1:0] lf;
    @(posedge PCLK); #1;
    xfer(1, 0, 8'h00, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (w !== 0 || rd !== 32'h0) begin miss_n++; $display("FAIL zw_read00 waits=%0d data=%h want 0/00000000", w, rd); end
    xfer(1, 0, 8'h04, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (w !== 0 || rd !== 32'h0) begin miss_n++; $display("FAIL zw_read04 waits=%0d data=%h want 0/00000000", w, rd); end
    xfer(1, 1, 8'h3C, 32'hA5A50001, 0, w, rd, er, lf);
    vec_n++; if (w !== 0 || er !== 1'b0) begin miss_n++; $display("FAIL zw_write3c waits=%0d err=%b want 0/0", w, er); end
    xfer(1, 0, 8'h3C, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (rd !== 32'hA5A50001 || er !== 1'b0) begin miss_n++; $display("FAIL zw_read3c data=%h err=%b want a5a50001/0", rd, er); end
  endtask

  task automatic test_write_read;
    int w; logic [31:0] rd; logic er; logic [1:0] lf;
    @(posedge PCLK); #1;
    xfer(0, 1, 8'h08, 32'hDEADBEEF, 1, w, rd, er, lf);
    vec_n++; if (w !== 2 || er !== 1'b0 || rd !== 32'h0) begin miss_n++; $display("FAIL wr08 waits=%0d err=%b data=%h want 2/0/0", w, er, rd); end
    @(negedge PCLK);
    vec_n++; if (pready2 !== 1'b0) begin miss_n++; $display("FAIL wr08_ready_drop got %b want 0", pready2); end
    @(posedge PCLK); #1;
    xfer(0, 0, 8'h08, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (w !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin miss_n++; $display("FAIL rd08 waits=%0d err=%b data=%h want 2/0/deadbeef", w, er, rd); end
    @(negedge PCLK);
    vec_n++; if (pready2 !== 1'b0 || prdata2 !== 32'h0) begin miss_n++; $display("FAIL rd08_clear ready=%b data=%h want 0/0", pready2, prdata2); end
    @(posedge PCLK); #1;
    xfer(0, 0, 8'h14, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (rd !== 32'h0) begin miss_n++; $display("FAIL rd14_untouched data=%h want 0", rd); end
  endtask

  task automatic test_out_of_range;
    int w; logic [31:0] rd; logic er; logic [1:0] lf;
    xfer(0, 1, 8'h40, 32'h12345678, 0, w, rd, er, lf);
    vec_n++; if (er !== 1'b1 || w !== 2) begin miss_n++; $display("FAIL oor_write err=%b waits=%0d want 1/2", er, w); end
    xfer(0, 0, 8'h40, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (er !== 1'b1 || rd !== 32'h0) begin miss_n++; $display("FAIL oor_read err=%b data=%h want 1/0", er, rd); end
    xfer(0, 0, 8'h00, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (er !== 1'b0 || rd !== 32'h0) begin miss_n++; $display("FAIL rd00_after_oor err=%b data=%h want 0/0", er, rd); end
    xfer(0, 0, 8'h3C, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (er !== 1'b0) begin miss_n++; $display("FAIL rd3c_in_range err=%b want 0", er); end
  endtask

  task automatic test_abort;
    int w; logic [31:0] rd; logic er; logic [1:0] lf;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hCAFEF00D;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    psel2 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      vec_n++; if (pready2 !== 1'b0) begin miss_n++; $display("FAIL abort_ready cycle %0d got %b want 0", i, pready2); end
    end
    @(posedge PCLK); #1;
    xfer(0, 0, 8'h0C, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (rd !== 32'h0 || w !== 2) begin miss_n++; $display("FAIL abort_rd0c data=%h waits=%0d want 0/2", rd, w); end
  endtask

  task automatic test_reset_mid;
    int w; logic [31:0] rd; logic er; logic [1:0] lf;
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h11112222;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    vec_n++; if ({pready2, pslverr2, prdata2} !== 34'h0) begin miss_n++; $display("FAIL rst_in_wait got %h want 0", {pready2, pslverr2, prdata2}); end
    @(posedge PCLK); #1;
    PRESET = 1'b0; psel2 = 1'b0; penable = 1'b0;
    // Reset while a read response is on the bus clears it asynchronously.
    xfer(0, 1, 8'h08, 32'h0BADF00D, 0, w, rd, er, lf);
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h08;
    @(posedge PCLK); #1;
    penable = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    vec_n++; if (pready2 !== 1'b1 || prdata2 !== 32'h0BADF00D) begin miss_n++; $display("FAIL pre_rst_read ready=%b data=%h want 1/0badf00d", pready2, prdata2); end
    PRESET = 1'b1;
    #1;
    vec_n++; if ({pready2, prdata2} !== 33'h0) begin miss_n++; $display("FAIL rst_in_done got %h want 0", {pready2, prdata2}); end
    @(posedge PCLK); #1;
    PRESET = 1'b0; psel2 = 1'b0; penable = 1'b0;
    xfer(0, 0, 8'h10, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (rd !== 32'h0) begin miss_n++; $display("FAIL rd10_after_rst data=%h want 0", rd); end
    xfer(0, 0, 8'h08, 32'h0, 0, w, rd, er, lf);
    vec_n++; if (rd !== 32'h0) begin miss_n++; $display("FAIL rd08_after_rst data=%h want 0", rd); end
  endtask

  task automatic test_rand_wait;
    int w; logic [31:0] rd; logic er; logic [1:0] lf;
    bit seen [4];
    for (int k = 0; k < 4; k++) seen[k] = 0;
    @(posedge PCLK); #1;
    for (int n = 0; n < 64; n++) begin
      xfer(0, n[0], 8'h04, 32'(n), 0, w, rd, er, lf);
      vec_n++; if (w !== int'(lf)) begin miss_n++; $display("FAIL rand_wait xfer %0d waits=%0d want %0d", n, w, lf); end
      if (w >= 0 && w < 4) seen[w] = 1;
    end
    for (int k = 0; k < 4; k++) begin
      vec_n++; if (seen[k] !== 1'b1) begin miss_n++; $display("FAIL rand_cover wait=%0d seen=%b want 1", k, seen[k]); end
    end
  endtask

  initial begin
    test_reset;
`ifdef APB_RAND_WAIT_EN
    test_rand_wait;
`else
    test_zero_wait;
    test_write_read;
    test_out_of_range;
    test_abort;
    test_reset_mid;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- APB3 completer that sits directly downstream of the APB protocol monitor and drives the PREADY it checks.
- Holds a small word-addressed register memory.
- Inserts a programmable number of wait states before completing each transfer, so the monitor's PREADY rise/fall covers are exercised in every phase.
- Flags out-of-range accesses with PSLVERR.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and of each memory word.
- ADDR_WIDTH, 8, width of PADDR (byte address; word index = PADDR[ADDR_WIDTH-1:2]).
- DEPTH, 16, number of implemented words; word index >= DEPTH is out of range.
- WAIT_CYCLES, 2, wait states inserted per transfer; legal range 0..15.

Ports:
- PCLK  input  1  APB clock; all state changes on rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PREADY  output  1  transfer-complete, registered.
- PRDATA  output  DATA_WIDTH  read data, registered; valid while PREADY=1 on a read.
- PSLVERR  output  1  error response, registered; valid only while PREADY=1.

Behaviour:
- Reset (PRESET=1, any time, including mid-transfer):
  - state=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, wait counter=0.
  - All DEPTH memory words cleared to 0.
  - Any in-flight write is discarded.
- States:
  - IDLE: no transfer active.
  - ACCESS: setup sampled, counting waits.
  - DONE: PREADY high, awaiting completion edge.
- IDLE, edge sampling PSEL=1 & PENABLE=0 (setup):
  - Latch PWRITE, PADDR, PWDATA.
  - Compute err = (word index >= DEPTH).
  - If WAIT_CYCLES=0: set PREADY=1 and go to DONE, so the first access cycle completes with zero wait.
  - Else: load counter=WAIT_CYCLES and go to ACCESS.
- IDLE, PENABLE=1 without a prior setup: ignored; PREADY stays 0 and state stays IDLE.
- ACCESS, each edge with PSEL=1 & PENABLE=1:
  - Decrement counter.
  - When counter==1 (the value before decrement), set PREADY=1 and go to DONE.
  - Total wait cycles with PREADY=0 during the access phase = WAIT_CYCLES exactly.
- PRDATA / PSLVERR load on the same edge that sets PREADY:
  - PSLVERR=err.
  - Read & !err: PRDATA=mem[index].
  - Read & err, or any write: PRDATA=0.
- DONE, edge sampling PSEL & PENABLE & PREADY (completion):
  - Write & !err: mem[index] <= latched PWDATA.
  - PREADY, PSLVERR, PRDATA cleared to 0; go to IDLE.
  - PREADY is high for exactly one cycle per transfer.
- Back-to-back transfers: the next setup is sampled on the edge after completion; no extra idle cycle is required.
- Abort: PSEL=0 sampled in ACCESS or DONE:
  - Return to IDLE, clear PREADY/PSLVERR/PRDATA.
  - No write is performed.
- Write data and address come from the setup-phase latch; changes on PADDR/PWDATA during wait cycles are ignored.
- Erroneous writes never modify memory.
- Counter width is 4 bits; no wrap-around is possible within the legal WAIT_CYCLES range.

Optional Feature:
- Macro: APB_RAND_WAIT_EN.
- Defined:
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4), reset seed 8'hA5, advancing every PCLK cycle regardless of bus activity.
  - At setup, the wait count = lfsr[1:0] (0..3) instead of WAIT_CYCLES; a value of 0 follows the zero-wait path.
- Not defined:
  - No LFSR logic exists.
  - The wait count is always WAIT_CYCLES.

Test Plan:
- Reset then idle 5 cycles -> PREADY, PSLVERR, PRDATA all 0 throughout; no state change.
- WAIT_CYCLES=2: write 32'hDEADBEEF to PADDR=8'h08, then read 8'h08:
  - Each transfer shows PREADY=0 for 2 access cycles, then PREADY=1 for 1 cycle.
  - Read returns PRDATA=32'hDEADBEEF, PSLVERR=0.
- WAIT_CYCLES=0: back-to-back reads of 8'h00 and 8'h04 after reset -> PREADY=1 in the first access cycle of each; PRDATA=0 for both.
- Out-of-range: write 32'h12345678 to PADDR=8'h40 (index 16) -> PSLVERR=1 with PREADY; subsequent read of 8'h40 gives PSLVERR=1, PRDATA=0; read of 8'h00 is unchanged.
- Abort: setup write of 32'hCAFEF00D to 8'h0C, drop PSEL after 1 wait cycle -> PREADY never rises; later read of 8'h0C returns 0.
- PRESET asserted during wait cycle 1 of a write to 8'h10 -> all outputs 0 immediately; read of 8'h10 after reset returns 0.
- APB_RAND_WAIT_EN defined: 64 transfers -> observed wait counts cover 0,1,2,3 and each matches lfsr[1:0] at setup.
